chunk_map_arbiter: RTL and testbench
====================================

Name: chunk_map_arbiter

Overview:
- Owns the 10x10 playfield chunk map: 100 entries, 4-bit chunk type each.
- Shares one single-port map RAM among three requesters: the VGA scan read (feeds the sprite renderer), the game-logic read (collision and lookup), and game-logic writes (buffered in a small queue).
- Sequences a full-map clear for level start and restart.
- Runs on the 100 MHz system clock. Uses the 2 LSBs of the clock divider to schedule the pixel-rate slot.

Parameters:
- WQ_DEPTH, 4, write-queue depth in entries; power of two, minimum 2.
- MAP_W, 10, map width and height in chunks.
- CHUNK_EMPTY, 4'h0, value returned for off-map reads and written by clear.

Ports:
- clk  in  1  100 MHz system clock
- rstn  in  1  asynchronous active-low reset
- phase  in  2  clock-divider bits [1:0]; phase==0 is the VGA slot
- vga_x  in  4  VGA chunk column
- vga_y  in  4  VGA chunk row
- vga_vld  in  1  VGA request qualifier (pixel in centre region)
- vga_dout  out  4  chunk type for the current pixel
- rd_req  in  1  logic read request; held until rd_gnt
- rd_x  in  4  logic read column
- rd_y  in  4  logic read row
- rd_gnt  out  1  one-cycle read grant
- rd_vld  out  1  one-cycle read-data valid
- rd_data  out  4  logic read data
- wr_en  in  1  queue a write; accepted only when !wr_full
- wr_x  in  4  write column
- wr_y  in  4  write row
- wr_data  in  4  write data
- wr_full  out  1  write queue full, or clear in progress
- clr_req  in  1  pulse; start full-map clear
- busy  out  1  clear in progress
- ovf  out  1  sticky: wr_en seen while wr_full

Behaviour:
- Address = y*MAP_W + x, 7 bits.
- A coordinate with x>=MAP_W or y>=MAP_W is off-map. An off-map read returns CHUNK_EMPTY and uses no slot. An off-map write is dropped at enqueue.
- Reset values: vga_dout=CHUNK_EMPTY, rd_gnt=0, rd_vld=0, rd_data=0, wr_full=0, busy=0, ovf=0; queue empty; map contents are all CHUNK_EMPTY.
- VGA slot:
  - On a cycle with phase==0 and vga_vld and an on-map address, the RAM is read for VGA.
  - vga_dout updates on the following edge (phase==1) and holds until the next update.
  - If vga_vld=0 or the address is off-map, vga_dout loads CHUNK_EMPTY at phase==1, and the phase-0 slot is free for logic.
- Logic slots: phases 1–3, plus phase 0 when the VGA slot is free. Per slot, one of the following, in priority order:
  1. Clear step.
  2. Queue-head write, if the queue is full or the pending read address matches any queued entry.
  3. Read, if rd_req.
  4. Queue-head write.
- Read handshake:
  - rd_gnt pulses in the cycle the RAM is read.
  - rd_vld and rd_data follow one cycle later.
  - Worst-case grant latency is 2 cycles when no writes are queued.
  - The requester must hold the address stable until rd_gnt.
- Write queue:
  - FIFO of {addr, data}.
  - An enqueue and a dequeue in the same cycle are both performed; the count is unchanged.
  - wr_full = (count==WQ_DEPTH) | busy.
  - wr_en while wr_full: the write is discarded and ovf is set.
- Clear:
  - clr_req while idle sets busy and writes CHUNK_EMPTY to addresses 0..99, one per cycle, using every slot including phase 0.
  - The queue is flushed and ovf is cleared at clear start.
  - During busy, vga_dout is CHUNK_EMPTY and rd_req is not granted.
  - busy drops the cycle after address 99 is written.
  - clr_req during busy restarts the clear at address 0.
- FSM states: IDLE, CLEAR. Transitions: IDLE->CLEAR on clr_req; CLEAR->IDLE after address 99.
- Reset mid-operation: asynchronously returns to IDLE, queue empty, clear aborted, outputs at reset values.

Optional Feature:
- Macro: ARB_FWD_EN.
- Defined: a read whose address matches a queued entry is granted without waiting for the write. rd_data is taken from the youngest matching queue entry, with the same rd_gnt/rd_vld timing as a RAM read.
- Undefined: the matching entry is forced to drain first, as in priority rule 2.

Decomposition:
- Shared package holds: MAP_W, CHUNK_EMPTY, the map address width (7), the chunk-type width (4), and the FSM state encoding.
- One sub-module, map_ram: 128x4 single-port, synchronous read (1 cycle), synchronous write, reset-initialised to CHUNK_EMPTY.

Test Plan:
- Write (3,2)=5, then VGA request at (3,2) on phase 0 -> vga_dout=5 from phase 1 onward; VGA request at (12,0) -> vga_dout=0.
- rd_req at (9,9) with the queue empty -> rd_gnt within 2 cycles; rd_vld with rd_data equal to the stored value one cycle after rd_gnt.
- 5 back-to-back wr_en with WQ_DEPTH=4 and rd_req held -> wr_full asserts, ovf=1, exactly 4 writes land; read waits until the queue drains.
- Write (1,1)=7 queued, then rd_req at (1,1) -> rd_data=7 (both with and without ARB_FWD_EN); with ARB_FWD_EN, rd_gnt precedes the RAM write.
- clr_req after filling the map -> busy high for 100 cycles, wr_full high, vga_dout=0; afterwards every read returns 0.
- rstn low during a clear at address 40 -> busy=0 immediately, the queue is empty, and ovf=0.

Source files
------------

// File: rtl/chunk_map_arbiter_pkg.sv
// Shared types and constants for the chunk map arbiter: map geometry, chunk encoding,
// write-queue entry layout and control FSM states.
package chunk_map_arbiter_pkg;

    localparam int MAP_W   = 10;
    localparam int ADDR_W  = 7;
    localparam int CHUNK_W = 4;

    localparam logic [CHUNK_W-1:0] CHUNK_EMPTY = 4'h0;
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = 7'd99;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [CHUNK_W-1:0] data;
    } wq_entry_t;

    function automatic logic chunk_on_map(input logic [3:0] x, input logic [3:0] y);
        return (x < 4'(MAP_W)) && (y < 4'(MAP_W));
    endfunction

    function automatic logic [ADDR_W-1:0] chunk_addr(input logic [3:0] x, input logic [3:0] y);
        return (ADDR_W'(y) * ADDR_W'(MAP_W)) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/chunk_map_arbiter_map_ram.sv
// 128x4 single-port map storage: synchronous read and write, contents reset to CHUNK_EMPTY.
module chunk_map_arbiter_map_ram
    import chunk_map_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [CHUNK_W-1:0] wdata,
    output logic [CHUNK_W-1:0] rdata
);

    logic [CHUNK_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [CHUNK_W-1:0] rdata_q;

    // Storage array and read register; rdata only moves on a read access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                mem_q[i] <= CHUNK_EMPTY;
            end
            rdata_q <= CHUNK_EMPTY;
        end else if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/chunk_map_arbiter.sv
// Arbitrates the shared map RAM between VGA scan, logic reads, queued logic writes and
// full-map clear. Define ARB_FWD_EN to forward queued write data to matching reads.
module chunk_map_arbiter
    import chunk_map_arbiter_pkg::*;
#(
    parameter int WQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [1:0]         phase,
    input  logic [3:0]         vga_x,
    input  logic [3:0]         vga_y,
    input  logic               vga_vld,
    output logic [CHUNK_W-1:0] vga_dout,
    input  logic               rd_req,
    input  logic [3:0]         rd_x,
    input  logic [3:0]         rd_y,
    output logic               rd_gnt,
    output logic               rd_vld,
    output logic [CHUNK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [3:0]         wr_x,
    input  logic [3:0]         wr_y,
    input  logic [CHUNK_W-1:0] wr_data,
    output logic               wr_full,
    input  logic               clr_req,
    output logic               busy,
    output logic               ovf
);

    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    arb_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  clr_q, clr_d;

    wq_entry_t          wq_q [0:WQ_DEPTH-1];
    logic [PTR_W-1:0]   wq_head_q, wq_tail_q;
    logic [CNT_W-1:0]   wq_cnt_q;
    logic               ovf_q;

    logic [CHUNK_W-1:0] vga_q;
    logic               vga_rd_q;
    logic               rd_vld_q;
    logic               rd_src_ram_q;
    logic [CHUNK_W-1:0] rd_data_q;

    logic               busy_s, wq_full_s, wq_empty_s, wr_full_s;
    logic               vga_use_s, rd_want_s, rd_on_s, rd_offmap_gnt_s;
    logic [ADDR_W-1:0]  vga_addr_s, rd_addr_s;
    logic               rd_hit_s, rd_fwd_s, drain_for_rd_s;
    logic [CHUNK_W-1:0] rd_fwd_data_s;
    logic               enq_s, deq_s, slot_rd_s, rd_ram_read_s, rd_gnt_s;
    wq_entry_t          wq_head_s, wr_entry_s;

    logic               ram_en_s, ram_we_s;
    logic [ADDR_W-1:0]  ram_addr_s;
    logic [CHUNK_W-1:0] ram_wdata_s, ram_rdata_s;

    assign busy_s      = (state_q == ST_CLEAR);
    assign wq_full_s   = (wq_cnt_q == CNT_W'(WQ_DEPTH));
    assign wq_empty_s  = (wq_cnt_q == {CNT_W{1'b0}});
    assign wr_full_s   = wq_full_s | busy_s;
    assign wq_head_s   = wq_q[wq_head_q];

    assign vga_addr_s  = chunk_addr(vga_x, vga_y);
    assign vga_use_s   = (phase == 2'd0) && vga_vld && chunk_on_map(vga_x, vga_y) && !busy_s;

    assign rd_addr_s       = chunk_addr(rd_x, rd_y);
    assign rd_on_s         = chunk_on_map(rd_x, rd_y);
    assign rd_want_s       = rd_req && !busy_s;
    // Off-map reads answer CHUNK_EMPTY without touching the RAM, so they never wait for a slot.
    assign rd_offmap_gnt_s = rd_want_s && !rd_on_s;

    assign wr_entry_s  = '{addr: chunk_addr(wr_x, wr_y), data: wr_data};
    assign enq_s       = wr_en && !wr_full_s && chunk_on_map(wr_x, wr_y);

    // Youngest queued entry matching the pending read address (later entries override).
    always_comb begin
        rd_hit_s      = 1'b0;
        rd_fwd_data_s = CHUNK_EMPTY;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            rd_hit_s      = rd_hit_s | ((CNT_W'(i) < wq_cnt_q) &&
                            (wq_q[PTR_W'(wq_head_q + PTR_W'(i))].addr == rd_addr_s));
            rd_fwd_data_s = ((CNT_W'(i) < wq_cnt_q) &&
                            (wq_q[PTR_W'(wq_head_q + PTR_W'(i))].addr == rd_addr_s)) ?
                            wq_q[PTR_W'(wq_head_q + PTR_W'(i))].data : rd_fwd_data_s;
        end
    end

`ifdef ARB_FWD_EN
    assign rd_fwd_s       = rd_hit_s;
    assign drain_for_rd_s = 1'b0;
`else
    assign rd_fwd_s       = 1'b0;
    assign drain_for_rd_s = rd_want_s && rd_on_s && rd_hit_s;
`endif

    // Slot owner for this cycle, highest priority first.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = vga_addr_s;
        ram_wdata_s = CHUNK_EMPTY;
        deq_s       = 1'b0;
        slot_rd_s   = 1'b0;
        if (vga_use_s) begin
            ram_en_s = 1'b1;
        end else if (busy_s) begin
            ram_en_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = clr_q;
        end else if (!wq_empty_s && (wq_full_s || drain_for_rd_s)) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = wq_head_s.addr;
            ram_wdata_s = wq_head_s.data;
            deq_s       = 1'b1;
        end else if (rd_want_s && rd_on_s) begin
            slot_rd_s  = 1'b1;
            ram_en_s   = !rd_fwd_s;
            ram_addr_s = rd_addr_s;
        end else if (!wq_empty_s) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = wq_head_s.addr;
            ram_wdata_s = wq_head_s.data;
            deq_s       = 1'b1;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    assign rd_ram_read_s = slot_rd_s && !rd_fwd_s;
    assign rd_gnt_s      = slot_rd_s || rd_offmap_gnt_s;

    // Clear sequencer next state; a new clr_req always restarts from address 0.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    clr_d   = 7'd0;
                end else begin
                    clr_d = 7'd0;
                end
            end
            ST_CLEAR: begin
                if (clr_req) begin
                    clr_d = 7'd0;
                end else if (clr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    clr_d   = 7'd0;
                end else begin
                    clr_d = clr_q + 7'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr_d   = 7'd0;
            end
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            clr_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Write queue storage, pointers and overflow flag; clear start flushes everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WQ_DEPTH; i++) begin
                wq_q[i] <= '{addr: 7'd0, data: CHUNK_EMPTY};
            end
            wq_head_q <= {PTR_W{1'b0}};
            wq_tail_q <= {PTR_W{1'b0}};
            wq_cnt_q  <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
        end else if (clr_req) begin
            wq_head_q <= {PTR_W{1'b0}};
            wq_tail_q <= {PTR_W{1'b0}};
            wq_cnt_q  <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            if (enq_s) begin
                wq_q[wq_tail_q] <= wr_entry_s;
                wq_tail_q       <= wq_tail_q + PTR_W'(1);
            end
            if (deq_s) begin
                wq_head_q <= wq_head_q + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   wq_cnt_q <= wq_cnt_q + CNT_W'(1);
                2'b01:   wq_cnt_q <= wq_cnt_q - CNT_W'(1);
                default: wq_cnt_q <= wq_cnt_q;
            endcase
            ovf_q <= ovf_q | (wr_en && wr_full_s);
        end
    end

    // VGA result: RAM data is shown directly in phase 1, then captured so it holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vga_q    <= CHUNK_EMPTY;
            vga_rd_q <= 1'b0;
        end else begin
            vga_rd_q <= vga_use_s;
            if (vga_rd_q) begin
                vga_q <= ram_rdata_s;
            end else if (phase == 2'd0) begin
                vga_q <= CHUNK_EMPTY;
            end
        end
    end

    // Logic read response: valid one cycle after grant, sourced from RAM or a captured value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_q     <= 1'b0;
            rd_src_ram_q <= 1'b0;
            rd_data_q    <= CHUNK_EMPTY;
        end else begin
            rd_vld_q <= rd_gnt_s;
            if (rd_gnt_s) begin
                rd_src_ram_q <= rd_ram_read_s;
                rd_data_q    <= rd_offmap_gnt_s ? CHUNK_EMPTY : rd_fwd_data_s;
            end
        end
    end

    chunk_map_arbiter_map_ram u_map_ram (
        .clk   (clk),
        .rstn  (rstn),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign vga_dout = busy_s ? CHUNK_EMPTY : (vga_rd_q ? ram_rdata_s : vga_q);
    assign rd_gnt   = rd_gnt_s;
    assign rd_vld   = rd_vld_q;
    assign rd_data  = rd_src_ram_q ? ram_rdata_s : rd_data_q;
    assign wr_full  = wr_full_s;
    assign busy     = busy_s;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_chunk_map_arbiter.sv
// Directed self-checking bench for chunk_map_arbiter (WQ_DEPTH=4); honours ARB_FWD_EN.
module tb_chunk_map_arbiter;

`ifdef ARB_FWD_EN
    localparam int FWD_LAT = 0;
`else
    localparam int FWD_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] phase = 2'd0;
    logic [3:0] vga_x = 4'd0, vga_y = 4'd0;
    logic       vga_vld = 1'b0;
    logic [3:0] vga_dout;
    logic       rd_req = 1'b0;
    logic [3:0] rd_x = 4'd0, rd_y = 4'd0;
    logic       rd_gnt, rd_vld;
    logic [3:0] rd_data;
    logic       wr_en = 1'b0;
    logic [3:0] wr_x = 4'd0, wr_y = 4'd0, wr_data = 4'd0;
    logic       wr_full;
    logic       clr_req = 1'b0;
    logic       busy, ovf;

    int n_vec = 0;
    int n_bad = 0;
    int n;

    chunk_map_arbiter #(.WQ_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .phase(phase),
        .vga_x(vga_x), .vga_y(vga_y), .vga_vld(vga_vld), .vga_dout(vga_dout),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt), .rd_vld(rd_vld),
        .rd_data(rd_data), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_full(wr_full), .clr_req(clr_req), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        phase = phase + 2'd1;
    endtask

    task automatic wait_phase0();
        while (phase != 2'd0) tick();
    endtask

    task automatic enqueue(input int x, input int y, input int d);
        wr_x = 4'(x); wr_y = 4'(y); wr_data = 4'(d); wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // exp_lat < 0 means "granted within 2 cycles".
    task automatic do_read(input int x, input int y, input int exp, input int exp_lat);
        int lat;
        rd_x = 4'(x); rd_y = 4'(y); rd_req = 1'b1;
        #1;
        lat = 0;
        while (!rd_gnt && lat < 8) begin
            tick();
            #1;
            lat++;
        end
        if (exp_lat < 0) check("gnt_within_2", int'(lat <= 2), 1);
        else check("gnt_latency", lat, exp_lat);
        tick();
        rd_req = 1'b0;
        #1;
        check("rd_vld", int'(rd_vld), 1);
        check("rd_data", int'(rd_data), exp);
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_vga_dout", int'(vga_dout), 0);
        check("rst_rd_gnt", int'(rd_gnt), 0);
        check("rst_rd_vld", int'(rd_vld), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_wr_full", int'(wr_full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        #2 rstn = 1'b1;

        // Write (3,2)=5 then VGA scan of it and of an off-map column
        enqueue(3, 2, 5);
        tick(); tick(); tick();
        wait_phase0();
        vga_x = 4'd3; vga_y = 4'd2; vga_vld = 1'b1;
        tick();
        vga_vld = 1'b0;
        check("vga_ph1", int'(vga_dout), 5);
        tick();
        check("vga_ph2_hold", int'(vga_dout), 5);
        tick();
        check("vga_ph3_hold", int'(vga_dout), 5);
        wait_phase0();
        vga_x = 4'd12; vga_y = 4'd0; vga_vld = 1'b1;
        tick();
        vga_vld = 1'b0;
        check("vga_offmap", int'(vga_dout), 0);

        // Logic read of (9,9) with the queue empty
        enqueue(9, 9, 10);
        tick(); tick(); tick();
        do_read(9, 9, 10, -1);
        tick();
        check("rd_vld_idle", int'(rd_vld), 0);
        do_read(15, 15, 0, 0);
        do_read(3, 2, 5, -1);

        // Off-map write is dropped: (10,0) would alias (0,1)
        enqueue(10, 0, 6);
        tick(); tick(); tick();
        do_read(0, 1, 0, -1);

        // Five back-to-back writes while a read keeps winning the slots
        rd_x = 4'd9; rd_y = 4'd9; rd_req = 1'b1;
        wr_en = 1'b1;
        wr_x = 4'd0; wr_y = 4'd0; wr_data = 4'd1; tick();
        wr_x = 4'd1; wr_data = 4'd2; tick();
        wr_x = 4'd2; wr_data = 4'd3; tick();
        wr_x = 4'd3; wr_data = 4'd4; tick();
        #1;
        check("wq_full_at_4", int'(wr_full), 1);
        check("ovf_before", int'(ovf), 0);
        check("rd_blocked_full", int'(rd_gnt), 0);
        wr_x = 4'd4; wr_data = 4'd5; tick();
        wr_en = 1'b0;
        check("ovf_set", int'(ovf), 1);
        check("wq_after_drain1", int'(wr_full), 0);
        rd_req = 1'b0;
        repeat (6) tick();
        check("ovf_sticky", int'(ovf), 1);
        do_read(0, 0, 1, -1);
        do_read(1, 0, 2, -1);
        do_read(2, 0, 3, -1);
        do_read(3, 0, 4, -1);
        do_read(4, 0, 0, -1);

        // Read hitting a queued write
        enqueue(1, 1, 7);
        do_read(1, 1, 7, FWD_LAT);
        tick(); tick();
        do_read(1, 1, 7, 0);

        // Full-map clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        rd_x = 4'd3; rd_y = 4'd2; rd_req = 1'b1;
        vga_x = 4'd3; vga_y = 4'd2; vga_vld = 1'b1;
        #1;
        check("clr_busy", int'(busy), 1);
        check("clr_wr_full", int'(wr_full), 1);
        check("clr_ovf_cleared", int'(ovf), 0);
        check("clr_vga_dout", int'(vga_dout), 0);
        check("clr_no_gnt", int'(rd_gnt), 0);
        n = 0;
        while (busy && n < 200) begin
            tick();
            #1;
            n++;
            if (n == 50) begin
                check("clr_mid_vga", int'(vga_dout), 0);
                check("clr_mid_gnt", int'(rd_gnt), 0);
                check("clr_mid_full", int'(wr_full), 1);
            end
        end
        rd_req = 1'b0;
        vga_vld = 1'b0;
        check("clr_busy_cycles", n, 100);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                do_read(x, y, 0, -1);
            end
        end

        // Reset in the middle of a clear (address 40)
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wr_x = 4'd5; wr_y = 4'd5; wr_data = 4'd9;
            wr_en = (k == 10);
            tick();
        end
        wr_en = 1'b0;
        check("mid_busy", int'(busy), 1);
        check("mid_ovf", int'(ovf), 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_wr_full", int'(wr_full), 0);
        check("arst_ovf", int'(ovf), 0);
        check("arst_rd_vld", int'(rd_vld), 0);
        check("arst_rd_data", int'(rd_data), 0);
        check("arst_vga", int'(vga_dout), 0);
        #1 rstn = 1'b1;
        tick();
        check("arst_idle", int'(busy), 0);

        // Queue empty after reset: exactly four entries fill it
        rd_x = 4'd9; rd_y = 4'd9; rd_req = 1'b1;
        enqueue(0, 9, 1);
        enqueue(1, 9, 2);
        enqueue(2, 9, 3);
        check("wq_3_not_full", int'(wr_full), 0);
        enqueue(3, 9, 4);
        check("wq_4_full", int'(wr_full), 1);
        rd_req = 1'b0;
        repeat (6) tick();
        do_read(3, 9, 4, -1);
        do_read(0, 9, 1, -1);
        do_read(5, 5, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
